// File: rtl/user_id_readout_ctrl.sv
// User project ID readout controller.
// Latches mask_rev into a shadow register, serves byte reads to two round-robin requesters and monitors ID integrity.
module user_id_readout_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'h0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] mask_rev,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [1:0]  sel_a,
  input  logic [1:0]  sel_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [7:0]  rdata,
  output logic        sdo,
  output logic        sdo_en,
  output logic        id_valid,
  output logic        id_mismatch
);

  localparam int unsigned ID_W   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    ST_LATCH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ID_W-1:0]   r_shadow,      w_shadow_nxt;
  logic [BYTE_W-1:0] r_shift,       w_shift_nxt;
  logic [BYTE_W-1:0] r_byte,        w_byte_nxt;
  logic [CNT_W-1:0]  r_cnt,         w_cnt_nxt;
  logic              r_gnt_b,       w_gnt_b_nxt;
  logic              r_prio_b,      w_prio_b_nxt;
  logic              r_ack_a,       w_ack_a_nxt;
  logic              r_ack_b,       w_ack_b_nxt;
  logic [BYTE_W-1:0] r_rdata,       w_rdata_nxt;
  logic              r_sdo,         w_sdo_nxt;
  logic              r_sdo_en,      w_sdo_en_nxt;
  logic              r_id_valid,    w_id_valid_nxt;
  logic              r_id_mismatch, w_id_mismatch_nxt;

  logic              w_idle_ok;
  logic              w_grant_a;
  logic              w_grant_b;
  logic [1:0]        w_sel;
  logic [BYTE_W-1:0] w_sel_byte;

  // Round-robin arbitration; r_prio_b flips to the loser after every grant
  assign w_idle_ok  = (r_state == ST_IDLE) && r_id_valid;
  assign w_grant_a  = w_idle_ok && req_a && (!req_b || !r_prio_b);
  assign w_grant_b  = w_idle_ok && req_b && (!req_a || r_prio_b);
  assign w_sel      = w_grant_a ? sel_a : sel_b;
  assign w_sel_byte = r_shadow[{w_sel, 3'b000} +: BYTE_W];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_LATCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LATCH: w_state_nxt = ST_IDLE;
      ST_IDLE:  if (w_grant_a || w_grant_b) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == LAST_BIT) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_LATCH;
    endcase
  end

  // Next values for all registered outputs and datapath state
  always_comb begin
    w_shadow_nxt      = r_shadow;
    w_shift_nxt       = r_shift;
    w_byte_nxt        = r_byte;
    w_cnt_nxt         = r_cnt;
    w_gnt_b_nxt       = r_gnt_b;
    w_prio_b_nxt      = r_prio_b;
    w_ack_a_nxt       = 1'b0;
    w_ack_b_nxt       = 1'b0;
    w_rdata_nxt       = r_rdata;
    w_sdo_nxt         = 1'b0;
    w_sdo_en_nxt      = 1'b0;
    w_id_valid_nxt    = r_id_valid;
    w_id_mismatch_nxt = r_id_mismatch | (r_id_valid & (mask_rev != r_shadow));
    case (r_state)
      ST_LATCH: begin
        w_shadow_nxt      = mask_rev;
        w_id_valid_nxt    = 1'b1;
        w_id_mismatch_nxt = r_id_mismatch | (mask_rev != EXPECTED_ID);
      end
      ST_IDLE: begin
        if (w_grant_a || w_grant_b) begin
          w_byte_nxt   = w_sel_byte;
          w_shift_nxt  = {w_sel_byte[BYTE_W-2:0], 1'b0};
          w_cnt_nxt    = '0;
          w_gnt_b_nxt  = w_grant_b;
          w_prio_b_nxt = w_grant_a;
          w_sdo_nxt    = w_sel_byte[BYTE_W-1];
          w_sdo_en_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == LAST_BIT) begin
          w_ack_a_nxt = ~r_gnt_b;
          w_ack_b_nxt = r_gnt_b;
          w_rdata_nxt = r_byte;
        end else begin
          w_sdo_nxt    = r_shift[BYTE_W-1];
          w_sdo_en_nxt = 1'b1;
          w_shift_nxt  = {r_shift[BYTE_W-2:0], 1'b0};
          w_cnt_nxt    = r_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_shadow      <= '0;
      r_shift       <= '0;
      r_byte        <= '0;
      r_cnt         <= '0;
      r_gnt_b       <= 1'b0;
      r_prio_b      <= 1'b0;
      r_ack_a       <= 1'b0;
      r_ack_b       <= 1'b0;
      r_rdata       <= '0;
      r_sdo         <= 1'b0;
      r_sdo_en      <= 1'b0;
      r_id_valid    <= 1'b0;
      r_id_mismatch <= 1'b0;
    end else begin
      r_shadow      <= w_shadow_nxt;
      r_shift       <= w_shift_nxt;
      r_byte        <= w_byte_nxt;
      r_cnt         <= w_cnt_nxt;
      r_gnt_b       <= w_gnt_b_nxt;
      r_prio_b      <= w_prio_b_nxt;
      r_ack_a       <= w_ack_a_nxt;
      r_ack_b       <= w_ack_b_nxt;
      r_rdata       <= w_rdata_nxt;
      r_sdo         <= w_sdo_nxt;
      r_sdo_en      <= w_sdo_en_nxt;
      r_id_valid    <= w_id_valid_nxt;
      r_id_mismatch <= w_id_mismatch_nxt;
    end
  end

  assign ack_a       = r_ack_a;
  assign ack_b       = r_ack_b;
  assign rdata       = r_rdata;
  assign sdo         = r_sdo;
  assign sdo_en      = r_sdo_en;
  assign id_valid    = r_id_valid;
  assign id_mismatch = r_id_mismatch;

endmodule

// File: tb/tb_user_id_readout_ctrl.sv
// Directed bench for user_id_readout_ctrl: a matching-ID instance and a mismatching-ID instance share stimulus.
module tb_user_id_readout_ctrl;

  localparam logic [31:0] ID = 32'hA5C31E7F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mask_rev, mask_rev_m;
  logic        req_a, req_b;
  logic [1:0]  sel_a, sel_b;
  logic        ack_a, ack_b, sdo, sdo_en, id_valid, id_mismatch;
  logic [7:0]  rdata;
  logic        m_ack_a, m_ack_b, m_sdo, m_sdo_en, m_id_valid, m_id_mismatch;
  logic [7:0]  m_rdata;

  typedef struct packed {
    logic       is_b;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_shadow;
  int          n_vec  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  user_id_readout_ctrl #(.EXPECTED_ID(ID)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .mask_rev(mask_rev),
    .req_a(req_a), .req_b(req_b), .sel_a(sel_a), .sel_b(sel_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .sdo(sdo), .sdo_en(sdo_en),
    .id_valid(id_valid), .id_mismatch(id_mismatch)
  );

  user_id_readout_ctrl #(.EXPECTED_ID(32'h0)) u_mis (
    .wb_clk_i(clk), .wb_rst_i(rst), .mask_rev(mask_rev_m),
    .req_a(req_a), .req_b(req_b), .sel_a(sel_a), .sel_b(sel_b),
    .ack_a(m_ack_a), .ack_b(m_ack_b), .rdata(m_rdata), .sdo(m_sdo), .sdo_en(m_sdo_en),
    .id_valid(m_id_valid), .id_mismatch(m_id_mismatch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] s);
    return v[{s, 3'b000} +: 8];
  endfunction

  task automatic push_exp(input logic is_b, input logic [1:0] s);
    exp_t e;
    e.is_b = is_b;
    e.data = byte_of(m_shadow, s);
    sb.push_back(e);
  endtask

  // Walks the 8 serial bits MSB first, then lands on the ack cycle
  task automatic shift_check(input logic [7:0] exp, input bit drop);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sdo_en", 32'(sdo_en), 1);
      chk("sdo", 32'(sdo), 32'(exp[7-i]));
      chk("ack_in_shift", 32'({ack_a, ack_b}), 0);
      if (drop && i == 1) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
    tick();
  endtask

  task automatic check_ack();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk("ack_a", 32'(ack_a), 32'(!e.is_b));
      chk("ack_b", 32'(ack_b), 32'(e.is_b));
      chk("rdata", 32'(rdata), 32'(e.data));
      chk("sdo_en_done", 32'(sdo_en), 0);
      chk("sdo_done", 32'(sdo), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mask_rev = ID; mask_rev_m = 32'h00000001;
    req_a = 1'b0; req_b = 1'b0; sel_a = 2'd0; sel_b = 2'd0;
    m_shadow = ID;
    repeat (3) tick();
    chk("rst_ack", 32'({ack_a, ack_b}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_sdo", 32'({sdo, sdo_en}), 0);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_mismatch", 32'(id_mismatch), 0);
    chk("rst_m_flags", 32'({m_id_valid, m_id_mismatch}), 0);

    // Latch: matching instance clean, mismatching instance flags at the same edge
    rst = 1'b0;
    tick();
    chk("latch_id_valid", 32'(id_valid), 1);
    chk("latch_id_mismatch", 32'(id_mismatch), 0);
    chk("latch_m_id_valid", 32'(m_id_valid), 1);
    chk("latch_m_id_mismatch", 32'(m_id_mismatch), 1);

    // Contention at the first IDLE edge: A first, then B
    req_a = 1'b1; sel_a = 2'd0; req_b = 1'b1; sel_b = 2'd3;
    push_exp(1'b0, 2'd0); push_exp(1'b1, 2'd3);
    shift_check(byte_of(m_shadow, 2'd0), 1'b0);
    check_ack();
    chk("m_ack_a", 32'(m_ack_a), 1);
    chk("m_rdata_sel0", 32'(m_rdata), 32'h01);
    req_a = 1'b0;
    tick();
    chk("gap_ack", 32'({ack_a, ack_b}), 0);
    chk("gap_sdo_en", 32'(sdo_en), 0);
    shift_check(byte_of(m_shadow, 2'd3), 1'b0);
    check_ack();
    req_b = 1'b0;
    tick();
    chk("ack_b_pulse", 32'(ack_b), 0);
    chk("rdata_hold", 32'(rdata), 32'hA5);

    // Next simultaneous request goes to A again, B follows
    req_a = 1'b1; sel_a = 2'd1; req_b = 1'b1; sel_b = 2'd2;
    push_exp(1'b0, 2'd1); push_exp(1'b1, 2'd2);
    shift_check(byte_of(m_shadow, 2'd1), 1'b0);
    check_ack();
    req_a = 1'b0;
    tick();
    shift_check(byte_of(m_shadow, 2'd2), 1'b0);
    check_ack();
    req_b = 1'b0;
    tick();

    // Single read A, sel 2
    req_a = 1'b1; sel_a = 2'd2;
    push_exp(1'b0, 2'd2);
    shift_check(8'hC3, 1'b0);
    check_ack();
    chk("single_mismatch", 32'(id_mismatch), 0);
    req_a = 1'b0;
    tick();
    chk("ack_a_pulse", 32'(ack_a), 0);
    chk("rdata_c3_hold", 32'(rdata), 32'hC3);

    // Early drop by B: transaction still completes, no re-grant
    req_b = 1'b1; sel_b = 2'd0;
    push_exp(1'b1, 2'd0);
    shift_check(8'h7F, 1'b1);
    check_ack();
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("no_regrant_ack", 32'({ack_a, ack_b}), 0);
      chk("no_regrant_sdo_en", 32'(sdo_en), 0);
    end

    // Live mask_rev glitch makes id_mismatch sticky; reads stay on the shadow
    mask_rev = ID ^ 32'h1;
    tick();
    chk("live_mismatch", 32'(id_mismatch), 1);
    mask_rev = ID;
    tick();
    chk("live_mismatch_sticky", 32'(id_mismatch), 1);
    mask_rev = ID ^ 32'h1;
    req_a = 1'b1; sel_a = 2'd0;
    push_exp(1'b0, 2'd0);
    shift_check(8'h7F, 1'b0);
    check_ack();
    req_a = 1'b0; mask_rev = ID;
    tick();

    // Reset mid-shift aborts without ack and re-latches
    req_a = 1'b1; sel_a = 2'd2;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("abort_sdo_en", 32'(sdo_en), 0);
    chk("abort_ack", 32'({ack_a, ack_b}), 0);
    chk("abort_rdata", 32'(rdata), 0);
    chk("abort_id_valid", 32'(id_valid), 0);
    chk("abort_id_mismatch", 32'(id_mismatch), 0);
    req_a = 1'b0;
    tick();
    chk("abort_ack2", 32'({ack_a, ack_b}), 0);
    rst = 1'b0;
    tick();
    chk("relatch_id_valid", 32'(id_valid), 1);
    chk("relatch_id_mismatch", 32'(id_mismatch), 0);

    req_a = 1'b1; sel_a = 2'd3;
    push_exp(1'b0, 2'd3);
    shift_check(8'hA5, 1'b0);
    check_ack();
    req_a = 1'b0;
    tick();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
